// File: rtl/dl_shift_pkg.sv
// rtl/dl_shift_pkg.sv - shared op encodings and helpers for the shift pipe
package dl_shift_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    SH_SRL = 2'b00,
    SH_SRA = 2'b01,
    SH_SLL = 2'b10,
    SH_ILL = 2'b11
  } sh_op_e;

  function automatic logic op_is_illegal(logic [OP_W-1:0] op);
    return op == SH_ILL;
  endfunction

endpackage

// File: rtl/dl_rshift_a.sv
// rtl/dl_rshift_a.sv - log-stage arithmetic right shifter, drops the sign/guard bit
module dl_rshift_a #(
  parameter int NUM_BITS = 33,
  parameter int SH_W     = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0] a,
  input  logic [SH_W-1:0]     sh,
  output logic [NUM_BITS-2:0] y
);

  // The top bit of a is the sign; it is replicated into vacated positions and
  // never appears itself in the result, so y is one bit narrower than a.
  localparam int W = NUM_BITS - 1;

  logic          sign;
  logic [W-1:0]  acc;
  logic [W-1:0]  ones;

  assign sign = a[NUM_BITS-1];
  assign ones = {W{1'b1}};

  // Barrel stages: stage k shifts by 2**k and back-fills with the sign bit.
  always_comb begin
    acc = a[W-1:0];
    for (int k = 0; k < SH_W; k++) begin
      if (sh[k]) begin
        acc = (acc >> (2 ** k)) | (~(ones >> (2 ** k)) & {W{sign}});
      end
    end
  end

  assign y = acc;

endmodule

// File: rtl/dl_shift_pipe.sv
// rtl/dl_shift_pipe.sv - two-stage valid/ready SLL/SRL/SRA unit
module dl_shift_pipe
  import dl_shift_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int TAG_W = 5,
  localparam int SHW   = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic             s1_valid;
  sh_op_e           s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [SHW-1:0]   s1_shamt;
  logic [XLEN-1:0]  s1_x;
  logic             s1_fill;

  logic             s1_ready;
  logic             s2_ready;

  logic [XLEN-1:0]  in_rev;
  logic [XLEN-1:0]  sh_res;
  logic [XLEN-1:0]  sh_rev;
  logic [XLEN-1:0]  res_data;

  // Ready chain depends only on registered valids, never on in_valid.
  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready && !rst;

  // Left shifts run through the right shifter on bit-reversed operands.
  for (genvar i = 0; i < XLEN; i++) begin : g_rev
    assign in_rev[i] = in_data[XLEN-1-i];
    assign sh_rev[i] = sh_res[XLEN-1-i];
  end

  // Stage 1: capture the request, pre-reverse SLL operands, pick the fill bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= SH_SRL;
      s1_tag   <= '0;
      s1_shamt <= '0;
      s1_x     <= '0;
      s1_fill  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op    <= sh_op_e'(in_op);
        s1_tag   <= in_tag;
        s1_shamt <= in_shamt;
        s1_x     <= (in_op == SH_SLL) ? in_rev : in_data;
        s1_fill  <= (in_op == SH_SRA) && in_data[XLEN-1];
      end
    end
  end

  dl_rshift_a #(
    .NUM_BITS(XLEN + 1),
    .SH_W    (SHW + 1)
  ) u_rshift (
    .a ({s1_fill, s1_x}),
    .sh({1'b0, s1_shamt}),
    .y (sh_res)
  );

  // Undo the reversal for SLL and force zero for the illegal encoding.
  always_comb begin
    res_data = sh_res;
    if (s1_op == SH_SLL) begin
      res_data = sh_rev;
    end else if (s1_op == SH_ILL) begin
      res_data = '0;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_data;
        out_tag  <= s1_tag;
        out_err  <= op_is_illegal(s1_op);
      end
    end
  end

endmodule

// File: tb/tb_dl_shift_pipe.sv
// tb/tb_dl_shift_pipe.sv - self-checking bench for dl_shift_pipe
module tb_dl_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
    logic        e;
  } res_t;

  dl_shift_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [31:0] d, logic [4:0] s, logic [1:0] op, logic [4:0] t);
    res_t r;
    r.t = t;
    r.e = 1'b0;
    case (op)
      2'b00: r.d = d >> s;
      2'b01: r.d = $signed(d) >>> s;
      2'b10: r.d = d << s;
      default: begin r.d = 32'h0; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_ops();
    logic [31:0] td [5];
    logic [4:0]  ts [5];
    logic [1:0]  to [5];
    logic [31:0] te [5];
    logic        tr [5];
    td = '{32'h8000_00F0, 32'h8000_00F0, 32'h0000_0001, 32'h1234_5678, 32'h7FFF_0000};
    ts = '{5'd4, 5'd4, 5'd31, 5'd7, 5'd31};
    to = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    te = '{32'hF800_000F, 32'h0800_000F, 32'h8000_0000, 32'h0, 32'h0};
    tr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = td[i]; in_shamt = ts[i]; in_op = to[i]; in_tag = 5'(i + 3);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL op%0d_in_ready: got %b want 1", i, in_ready); end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL op%0d_early_valid: got %b want 0", i, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL op%0d_valid: got %b want 1", i, out_valid); end
      total++; if (out_data !== te[i]) begin bad++; $display("FAIL op%0d_data: got %h want %h", i, out_data, te[i]); end
      total++; if (out_err !== tr[i]) begin bad++; $display("FAIL op%0d_err: got %b want %b", i, out_err, tr[i]); end
      total++; if (out_tag !== 5'(i + 3)) begin bad++; $display("FAIL op%0d_tag: got %h want %h", i, out_tag, 5'(i + 3)); end
    end
  endtask

  task automatic test_shamt_zero();
    out_ready = 1'b1;
    for (int op = 0; op < 3; op++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd0; in_op = 2'(op); in_tag = 5'(op);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_err !== 1'b0) begin
        bad++; $display("FAIL shamt0_op%0d: got v=%b d=%h e=%b want v=1 d=deadbeef e=0", op, out_valid, out_data, out_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t exp [8];
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        in_shamt = 5'($urandom);
        in_op    = 2'($urandom_range(0, 2));
        in_tag   = 5'(c + 10);
        exp[c]   = model(in_data, in_shamt, in_op, in_tag);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (c >= 2) begin
        total++;
        if (out_valid !== 1'b1 || {out_data, out_tag, out_err} !== exp[c-2]) begin
          bad++; $display("FAIL b2b_result%0d: got v=%b %h/%h/%b want %h/%h/%b", c - 2, out_valid,
                          out_data, out_tag, out_err, exp[c-2].d, exp[c-2].t, exp[c-2].e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    res_t exp [3];
    int   idx = 0;
    int   got = 0;
    logic [31:0] held = '0;
    logic        have = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp[i] = model($urandom, 5'($urandom), 2'($urandom_range(0, 3)), 5'(20 + i));
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 5);
      in_valid  = (idx < 3);
      if (idx < 3) begin
        in_data = 32'h0; in_shamt = '0; in_op = 2'b11; in_tag = exp[idx].t;
        if (!exp[idx].e) begin
          in_data = 32'hA5C3_0F17 + 32'(idx); in_shamt = 5'(idx * 7 + 3); in_op = 2'(idx % 3);
          exp[idx] = model(in_data, in_shamt, in_op, in_tag);
        end
      end
      @(negedge clk);
      if (c == 4) begin
        total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      end
      if (c < 5 && out_valid) begin
        if (have) begin
          total++; if (out_data !== held) begin bad++; $display("FAIL bp_stable: got %h want %h", out_data, held); end
        end
        held = out_data; have = 1'b1;
      end
      if (out_valid && out_ready) begin
        total++;
        if (got >= 3) begin
          bad++; $display("FAIL bp_extra: got %h want no result", out_data);
        end else if ({out_data, out_tag, out_err} !== exp[got]) begin
          bad++; $display("FAIL bp_order%0d: got %h/%h/%b want %h/%h/%b", got, out_data, out_tag, out_err,
                          exp[got].d, exp[got].t, exp[got].e);
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    total++; if (got !== 3) begin bad++; $display("FAIL bp_drained: got %0d want 3", got); end
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'b00; in_tag = 5'(c);
      if (c == 2) begin flush = 1'b1; out_ready = 1'b1; end
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_fill_ready c%0d: got %b want 1", c, in_ready); end
    end
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_next_valid: got %b want 0", out_valid); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_ghost: got %0d results want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = $urandom | 32'h1; in_shamt = 5'd1; in_op = 2'b10; in_tag = 5'(c + 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0) begin
      bad++; $display("FAIL rst_mid_state: got v=%b d=%h t=%h want 0/0/0", out_valid, out_data, out_tag);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_ghost: got %0d results want 0", seen); end
  endtask

  task automatic test_random();
    res_t expq[$];
    res_t hv;
    res_t r;
    logic held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = (c < 350) && ($urandom_range(0, 9) < 7);
      out_ready = (c >= 350) || ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_shamt  = 5'($urandom);
      in_op     = 2'($urandom_range(0, 3));
      in_tag    = 5'($urandom);
      @(negedge clk);
      if (held) begin
        total++;
        if (out_valid !== 1'b1 || {out_data, out_tag, out_err} !== hv) begin
          bad++; $display("FAIL rnd_hold c%0d: got v=%b %h want %h", c, out_valid, out_data, hv.d);
        end
      end
      held = out_valid && !out_ready;
      hv   = {out_data, out_tag, out_err};
      if (out_valid && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected c%0d: got %h want none", c, out_data);
        end else begin
          r = expq.pop_front();
          if ({out_data, out_tag, out_err} !== r) begin
            bad++; $display("FAIL rnd_result c%0d: got %h/%h/%b want %h/%h/%b", c, out_data, out_tag, out_err,
                            r.d, r.t, r.e);
          end
        end
      end
      if (in_valid && in_ready) expq.push_back(model(in_data, in_shamt, in_op, in_tag));
    end
    in_valid = 1'b0;
    total++; if (expq.size() != 0) begin bad++; $display("FAIL rnd_leftover: got %0d pending want 0", expq.size()); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_shamt_zero();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dl_shift_pipe.md
Name: dl_shift_pipe

Overview:
- Two-stage valid/ready pipelined shift unit for the RV32 execute path. Handles SLL, SRL and SRA on XLEN-bit operands.
- Stage 1 prepares operands: captures the request, bit-reverses for left shifts and selects the fill bit. It then feeds the combinational right-arithmetic shifter.
- Stage 2 captures the shifter result, undoes the reversal, and holds it under backpressure until the consumer accepts it.

Parameters:
- XLEN, 32, operand/result width; power of two, ≥ 4.
- TAG_W, 5, width of the opaque tag carried alongside each request (e.g. rd index).
- SHW, $clog2(XLEN) (localparam), shift-amount width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all in-flight ops
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- in_data  in  XLEN  operand
- in_shamt  in  SHW  shift amount
- in_op  in  2  00 SRL, 01 SRA, 10 SLL, 11 illegal
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  XLEN  shift result
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  result came from an illegal op

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Once out_valid is asserted, out_data, out_tag and out_err are held stable until the output transfer.
- Ready chain:
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready && !rst
  - No combinational path from in_valid to in_ready.
- Throughput and latency:
  - One op per cycle sustained while out_ready stays high.
  - Latency is 2 cycles: an op accepted at edge N presents out_valid after edge N+1.
- Stage 1 registers: s1_valid, s1_op, s1_tag, s1_shamt, and operand s1_x.
  - For SLL, s1_x = bit-reverse(in_data); otherwise s1_x = in_data.
  - Fill bit: s1_fill = in_data[XLEN-1] for SRA, 0 otherwise.
- Combinational shift between stages:
  - The shifter is given {s1_fill, s1_x} (XLEN+1 bits) and shift = zero-extended s1_shamt.
  - Take the low XLEN bits of its output.
  - This yields a logical shift for SRL/SLL and an arithmetic shift for SRA.
- Stage 2 registers: out_valid, out_data, out_tag, out_err.
  - For SLL, out_data = bit-reverse(shifter result).
  - For op 11, out_data = 0 and out_err = 1.
  - For all other ops, out_err = 0.
- Boundary conditions:
  - shamt = 0 gives out_data = in_data for all legal ops.
  - shamt = XLEN-1 gives:
    - SRA: all bits equal to the sign.
    - SRL: only bit 0 = in_data[XLEN-1].
    - SLL: only bit XLEN-1 = in_data[0].
- Stall: while out_valid && !out_ready, stage 2 holds. Stage 1 holds if s1_valid, and in_ready drops.
- Simultaneous events: an out transfer and a stage1→stage2 move in the same cycle is legal and loses no bubble. An in transfer in that same cycle is also legal.
- flush:
  - At the edge, clears s1_valid and out_valid regardless of out_ready.
  - A request handshaked in the flush cycle is also dropped.
  - Data registers keep their values.
- Reset:
  - All valids = 0, out_data = 0, out_tag = 0, out_err = 0.
  - in_ready = 0 while rst is high.
  - Reset mid-operation discards all in-flight ops; no output transfer completes on the reset edge.
- Precedence: rst > flush > normal operation.

Decomposition:
- Shared package/header `dl_shift_pkg`:
  - Op encodings SH_SRL = 2'b00, SH_SRA = 2'b01, SH_SLL = 2'b10.
  - Op width constant.
- One sub-module: dl_rshift_a, instantiated with NUM_BITS = XLEN+1.
- Bit-reverse is a local generate loop, not a separate module.

Test Plan:
- SRA: in_data = 0x8000_00F0, shamt = 4, out_ready = 1 → out_data = 0xF800_000F, out_err = 0, out_valid 2 cycles after accept; the tag is echoed.
- SRL / SLL / illegal:
  - SRL in_data = 0x8000_00F0, shamt = 4 → 0x0800_000F.
  - SLL in_data = 0x0000_0001, shamt = 31 → 0x8000_0000.
  - op = 11 → out_data = 0, out_err = 1.
- shamt = 0 on 0xDEAD_BEEF for all three legal ops → 0xDEAD_BEEF each time.
- Back-to-back stream: 8 ops, one per cycle, out_ready = 1 → 8 results on consecutive cycles in order, in_ready constantly 1.
- Backpressure: out_ready = 0 for 5 cycles with 3 ops offered → the first 2 are accepted, in_ready = 0, and out_data stays stable. Releasing out_ready drains all 3 in order with no loss or duplication.
- Flush and reset:
  - flush with both stages full, while in_valid = 1 → next cycle out_valid = 0, and no result for any of the three ops ever appears.
  - rst mid-stream → all valids are 0 the following cycle, and in_ready = 0 during rst.
